program_loader: RTL and testbench

//  Byte-stream writer that fills instruction memory before the pipelined core fetches from it.

---
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian program image into instruction memory and holds the core in reset until the load finishes.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDRESS_WIDTH      = 32,
    parameter int ADDRESS_REAL_WIDTH = 12,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          mem_we,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          cpu_rst,
    output logic                          load_done,
    output logic                          load_err,
    output logic [ADDRESS_REAL_WIDTH-1:0] words_loaded
);

    localparam int MAXW = 2 ** (ADDRESS_REAL_WIDTH - 2);

    localparam logic [2:0] S_LEN  = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd2;
    localparam logic [2:0] S_TAIL = S_CHK;
`else
    localparam logic [2:0] S_TAIL = S_DONE;
`endif

    logic [2:0]                    state;
    logic [1:0]                    byte_idx;
    logic [23:0]                   shreg;
    logic [ADDRESS_REAL_WIDTH-1:0] word_count;
    logic [31:0]                   assembled;
    logic                          accept;
    logic                          last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                    csum;
`endif

    assign accept    = in_valid & in_ready;
    assign assembled = {in_data, shreg};
    assign last_word = (words_loaded + ADDRESS_REAL_WIDTH'(1)) == word_count;

    assign in_ready  = !((state == S_DONE) || (state == S_ERR));
    assign load_done = (state == S_DONE);
    assign load_err  = (state == S_ERR);
    assign cpu_rst   = !load_done;

    // Bytes shift in from the top so that after three bytes the low 24 bits
    // hold them LSB first; the fourth byte completes the word directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LEN;
            byte_idx     <= 2'd0;
            shreg        <= '0;
            word_count   <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= 8'h00;
`endif
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                words_loaded <= words_loaded + ADDRESS_REAL_WIDTH'(1);
            end
            if (accept) begin
                case (state)
                    S_LEN: begin
                        byte_idx <= byte_idx + 2'd1;
                        shreg    <= {in_data, shreg[23:8]};
                        if (byte_idx == 2'd3) begin
                            word_count <= assembled[ADDRESS_REAL_WIDTH-1:0];
                            if (assembled > 32'(MAXW)) begin
                                state <= S_ERR;
                            end else if (assembled == 32'd0) begin
                                state <= S_TAIL;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        shreg    <= {in_data, shreg[23:8]};
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        // words_loaded already counts every earlier write,
                        // since writes are at least four transfers apart.
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= assembled;
                            mem_addr  <= BASE_ADDR + ADDRESS_WIDTH'({words_loaded, 2'b00});
                            if (last_word) begin
                                state <= S_TAIL;
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHK: begin
                        state <= (in_data == csum) ? S_DONE : S_ERR;
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: cycle-level vector table plus scripted multi-cycle image loads.
// Builds with or without LOADER_CHECKSUM_EN.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;
    logic [11:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] img[$];

    typedef struct {
        logic        rst;
        logic        valid;
        logic [7:0]  data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        done;
        logic        err;
        logic        crst;
        logic [11:0] words;
    } vec_t;

    vec_t vecs[$];

    program_loader dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst),
        .load_done(load_done),
        .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Scoreboard of every memory write, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
        rst      = r;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic r, input logic v, input logic [7:0] d, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic ready,
                          input logic done, input logic err, input logic crst, input logic [11:0] words);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.we = we; t.addr = addr; t.wdata = wdata;
        t.ready = ready; t.done = done; t.err = err; t.crst = crst; t.words = words;
        vecs.push_back(t);
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gap);
        applyStimulus(1'b0, 1'b1, b);
        if (gap) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Streams length, payload (optionally cut short) and, when enabled, the checksum byte
    task automatic loadImage(input int n, input int stop_after, input bit gap, input bit bad_chk);
        logic [31:0] nn;
        logic [7:0]  chk;
        logic [31:0] w;
        nn  = n;
        chk = 8'h00;
        for (int i = 0; i < 4; i++) sendByte(nn[8*i +: 8], gap);
        for (int k = 0; k < n; k++) begin
            w = img[k];
            for (int b = 0; b < 4; b++) begin
                if (stop_after >= 0 && (k * 4 + b) >= stop_after) return;
                chk = chk ^ w[8*b +: 8];
                sendByte(w[8*b +: 8], gap);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        sendByte(bad_chk ? (chk ^ 8'h01) : chk, gap);
`else
        if (bad_chk) chk = 8'h00;
`endif
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic checkWrites(input string name, input int n);
        int m;
        checkOutput({name, "_count"}, 128'(wr_addr_q.size()), 128'(n));
        m = (wr_addr_q.size() < n) ? wr_addr_q.size() : n;
        for (int k = 0; k < m; k++) begin
            checkOutput($sformatf("%s_addr%0d", name, k), 128'(wr_addr_q[k]), 128'(4 * k));
            checkOutput($sformatf("%s_data%0d", name, k), 128'(wr_data_q[k]), 128'(img[k]));
        end
    endtask

    initial begin
        // Single-word image, cycle by cycle
        addVec(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h01, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 0, 8'h77, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h13, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h05, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'hA0, 0, 0, 0, 1, 0, 0, 1, 0);
`ifdef LOADER_CHECKSUM_EN
        addVec(0, 1, 8'h02, 1, 0, 32'h02A00513, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'hB4, 0, 0, 32'h02A00513, 0, 1, 0, 0, 1);
`else
        addVec(0, 1, 8'h02, 1, 0, 32'h02A00513, 0, 1, 0, 0, 0);
`endif
        addVec(0, 0, 8'h00, 0, 0, 32'h02A00513, 0, 1, 0, 0, 1);
        addVec(0, 1, 8'hFF, 0, 0, 32'h02A00513, 0, 1, 0, 0, 1);
        // Oversized length: N = 1025
        addVec(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h01, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h04, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0);
        addVec(0, 1, 8'h13, 0, 0, 0, 0, 0, 1, 1, 0);
        addVec(0, 1, 8'h05, 0, 0, 0, 0, 0, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data);
            checkOutput($sformatf("vec%0d", i),
                        128'({mem_we, mem_addr, mem_wdata, in_ready, load_done, load_err, cpu_rst, words_loaded}),
                        128'({vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready, vecs[i].done,
                              vecs[i].err, vecs[i].crst, vecs[i].words}));
        end

        // Three words with in_valid toggling every other cycle
        resetDut();
        img = '{32'h11223344, 32'hDEADBEEF, 32'h00000001};
        loadImage(3, -1, 1'b1, 1'b0);
        checkWrites("gap", 3);
        checkOutput("gap_done", 128'(load_done), 128'(1));
        checkOutput("gap_cpu_rst", 128'(cpu_rst), 128'(0));
        checkOutput("gap_ready", 128'(in_ready), 128'(0));
        checkOutput("gap_words", 128'(words_loaded), 128'(3));

        // Empty image
        resetDut();
        img.delete();
        loadImage(0, -1, 1'b0, 1'b0);
        checkWrites("empty", 0);
        checkOutput("empty_done", 128'(load_done), 128'(1));
        checkOutput("empty_words", 128'(words_loaded), 128'(0));
`ifdef LOADER_CHECKSUM_EN
        resetDut();
        loadImage(0, -1, 1'b0, 1'b1);
        checkOutput("empty_badchk_err", 128'(load_err), 128'(1));
        checkOutput("empty_badchk_done", 128'(load_done), 128'(0));
`endif

        // Reset mid-load, then a complete two-word image
        resetDut();
        img = '{32'hA1A2A3A4, 32'hB1B2B3B4};
        loadImage(2, 6, 1'b0, 1'b0);
        resetDut();
        checkOutput("midrst_words", 128'(words_loaded), 128'(0));
        checkOutput("midrst_addr", 128'(mem_addr), 128'(0));
        img = '{32'hCAFEF00D, 32'h12345678};
        loadImage(2, -1, 1'b0, 1'b0);
        checkWrites("reload", 2);
        checkOutput("reload_words", 128'(words_loaded), 128'(2));
        checkOutput("reload_done", 128'(load_done), 128'(1));

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum after a complete payload
        resetDut();
        img = '{32'h00112233, 32'h44556677};
        loadImage(2, -1, 1'b0, 1'b1);
        checkWrites("badchk", 2);
        checkOutput("badchk_err", 128'(load_err), 128'(1));
        checkOutput("badchk_done", 128'(load_done), 128'(0));
        checkOutput("badchk_cpu_rst", 128'(cpu_rst), 128'(1));
        checkOutput("badchk_ready", 128'(in_ready), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
